// File: rtl/ready_register.sv
// ready_register: backward-path register slice (skid buffer) for a valid/ready
// handshake. Every output comes from a flop, so there is no combinational path
// from s_ready to m_ready. Sustains one beat per clock with strict FIFO order.
//
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset
//   m_valid - upstream beat valid
//   m_ready - upstream ready (registered)
//   m_data  - upstream beat data
//   s_valid - downstream beat valid (registered)
//   s_ready - downstream ready
//   s_data  - downstream beat data (registered)
//   level   - occupancy in beats: 0, 1 or 2 (registered)
module ready_register #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m_valid,
  output logic             m_ready,
  input  logic [WIDTH-1:0] m_data,
  output logic             s_valid,
  input  logic             s_ready,
  output logic [WIDTH-1:0] s_data,
  output logic [1:0]       level
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             m_ready_q, m_ready_d;
  logic             s_valid_q, s_valid_d;
  logic [1:0]       level_q, level_d;
  logic             accept;
  logic             consume;

  assign accept  = m_valid && m_ready_q;
  assign consume = s_valid_q && s_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          out_d   = m_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept && consume) begin
          out_d = m_data;
        end else if (accept) begin
          // Downstream stalled: park the new beat behind the one on s_data.
          skid_d  = m_data;
          state_d = FULL;
        end else if (consume) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (consume) begin
          out_d   = skid_q;
          state_d = BUSY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase

    // Outputs are registered copies of what the next state implies.
    m_ready_d = (state_d != FULL);
    s_valid_d = (state_d != EMPTY);
    unique case (state_d)
      BUSY:    level_d = 2'd1;
      FULL:    level_d = 2'd2;
      default: level_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      out_q     <= '0;
      skid_q    <= '0;
      // Held low through reset and for one cycle after it, so nothing is
      // accepted until the slice has come out of reset cleanly.
      m_ready_q <= 1'b0;
      s_valid_q <= 1'b0;
      level_q   <= '0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      skid_q    <= skid_d;
      m_ready_q <= m_ready_d;
      s_valid_q <= s_valid_d;
      level_q   <= level_d;
    end
  end

  assign m_ready = m_ready_q;
  assign s_valid = s_valid_q;
  assign s_data  = out_q;
  assign level   = level_q;

endmodule

// File: tb/tb_ready_register.sv
module tb_ready_register;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_valid = 1'b0;
  logic       m_ready;
  logic [7:0] m_data = '0;
  logic       s_valid;
  logic       s_ready = 1'b0;
  logic [7:0] s_data;
  logic [1:0] level;

  ready_register #(.WIDTH(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .level   (level)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  logic [7:0] sb_q[$];
  int   acc_cnt  = 0;
  int   cons_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus. Inputs change just after a rising edge; the beat
  // is recorded as expected output once it is known it will be accepted.
  task automatic step(input logic mv, input logic [7:0] md, input logic sr);
    m_valid = mv;
    m_data  = md;
    s_ready = sr;
    @(negedge clk);
    #1;
    if (m_valid && m_ready && !rst) begin
      sb_q.push_back(m_data);
      acc_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples mid-cycle, compares consumed beats against the queue
  // and checks the structural invariants every cycle.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  logic       prev_rst   = 1'b1;
  logic [7:0] exp_beat;

  always begin
    @(negedge clk);
    if (rst) begin
      prev_stall = 1'b0;
      prev_rst   = 1'b1;
    end else begin
      chk("level_vs_depth", 32'(level), 32'(sb_q.size()));
      chk("level_max", 32'(level <= 2'd2), 32'd1);
      chk("count_balance", 32'(acc_cnt), 32'(cons_cnt + int'(level)));
      chk("m_ready", 32'(m_ready), prev_rst ? 32'd0 : 32'(sb_q.size() < 2));
      chk("s_valid", 32'(s_valid), 32'(sb_q.size() != 0));
      if (prev_stall) begin
        chk("stall_valid", 32'(s_valid), 32'd1);
        chk("stall_data", 32'(s_data), 32'(prev_data));
      end
      if (s_valid && s_ready) begin
        if (sb_q.size() == 0) begin
          chk("pop_empty", 32'(sb_q.size()), 32'd1);
        end else begin
          exp_beat = sb_q.pop_front();
          chk("beat_data", 32'(s_data), 32'(exp_beat));
          cons_cnt++;
        end
      end
      prev_stall = s_valid && !s_ready;
      prev_data  = s_data;
      prev_rst   = 1'b0;
    end
  end

  initial begin
    // Power-on reset.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("por_s_valid", 32'(s_valid), 32'd0);
    chk("por_level", 32'(level), 32'd0);
    chk("por_s_data", 32'(s_data), 32'd0);
    chk("por_m_ready", 32'(m_ready), 32'd0);
    step(1'b0, 8'h00, 1'b0);
    chk("por_m_ready_rise", 32'(m_ready), 32'd1);

    // Streaming with 1-cycle latency.
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b1);
      chk("stream_data", 32'(s_data), 32'(i));
      chk("stream_valid", 32'(s_valid), 32'd1);
      chk("stream_m_ready", 32'(m_ready), 32'd1);
      chk("stream_level", 32'(level), 32'd1);
    end
    step(1'b0, 8'h00, 1'b1);
    chk("stream_end_level", 32'(level), 32'd0);

    // Backpressure fill.
    step(1'b1, 8'hA1, 1'b0);
    chk("fill1_level", 32'(level), 32'd1);
    chk("fill1_data", 32'(s_data), 32'hA1);
    chk("fill1_m_ready", 32'(m_ready), 32'd1);
    step(1'b1, 8'hA2, 1'b0);
    chk("fill2_level", 32'(level), 32'd2);
    chk("fill2_data", 32'(s_data), 32'hA1);
    chk("fill2_m_ready", 32'(m_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'hA3, 1'b0);
      chk("hold_level", 32'(level), 32'd2);
      chk("hold_data", 32'(s_data), 32'hA1);
      chk("hold_m_ready", 32'(m_ready), 32'd0);
    end

    // Drain, A3 still offered upstream.
    step(1'b1, 8'hA3, 1'b1);
    chk("drain1_data", 32'(s_data), 32'hA2);
    chk("drain1_level", 32'(level), 32'd1);
    chk("drain1_m_ready", 32'(m_ready), 32'd1);
    step(1'b1, 8'hA3, 1'b1);
    chk("drain2_data", 32'(s_data), 32'hA3);
    chk("drain2_level", 32'(level), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    chk("drain3_level", 32'(level), 32'd0);
    chk("drain3_valid", 32'(s_valid), 32'd0);

    // Reset mid-stream while full.
    step(1'b1, 8'hB1, 1'b0);
    step(1'b1, 8'hB2, 1'b0);
    chk("pre_rst_level", 32'(level), 32'd2);
    rst = 1'b1;
    sb_q.delete();
    acc_cnt  = 0;
    cons_cnt = 0;
    step(1'b1, 8'hB3, 1'b0);
    step(1'b1, 8'hB3, 1'b0);
    rst = 1'b0;
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_s_data", 32'(s_data), 32'd0);
    chk("rst_m_ready", 32'(m_ready), 32'd0);
    step(1'b1, 8'hB3, 1'b0);
    chk("rst_m_ready_rise", 32'(m_ready), 32'd1);
    chk("rst_no_accept", 32'(level), 32'd0);
    step(1'b1, 8'hB3, 1'b1);
    chk("rst_first_beat", 32'(s_data), 32'hB3);
    step(1'b0, 8'h00, 1'b1);
    chk("rst_drained", 32'(level), 32'd0);

    // Alternating ready with continuous valid.
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(8'h40 + i), 1'(i % 2));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    chk("bubble_empty", 32'(sb_q.size()), 32'd0);

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    chk("final_empty", 32'(sb_q.size()), 32'd0);
    chk("final_level", 32'(level), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
